// File: rtl/skew_sr_pkg.sv
// -----------------------------------------------------------------------------
// skew_sr_pkg
// Shared helpers for the skew/deskew shift register.
//   lane_depth(c, n_ch, base_depth, step, reverse)
//     Number of enabled edges channel c delays its data.
//     reverse = 0 : depth grows with channel index (skew).
//     reverse = 1 : depth shrinks with channel index (deskew).
// -----------------------------------------------------------------------------
package skew_sr_pkg;

  function automatic int lane_depth(input int c,
                                    input int n_ch,
                                    input int base_depth,
                                    input int step,
                                    input int reverse);
    int idx_s;
    if (reverse != 32'sd0) begin
      idx_s = n_ch - 32'sd1 - c;
    end else begin
      idx_s = c;
    end
    return base_depth + idx_s * step;
  endfunction

endpackage

// File: rtl/skew_sr_lane.sv
// -----------------------------------------------------------------------------
// skew_sr_lane
// Single-channel delay line of DEPTH stages. Stage 0 captures the input on an
// enabled edge; the last stage drives the outputs directly.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_en          shift enable (0 = hold every stage)
//   i_flush       synchronous clear of the valid stages only
//   i_dat_vld     input valid
//   i_dat         input data
//   o_dat_vld     valid of the last stage
//   o_dat         data of the last stage
//   o_busy        OR of every valid stage in this lane
// -----------------------------------------------------------------------------
module skew_sr_lane #(
  parameter int DEPTH     = 1,
  parameter int DAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_flush,
  input  logic                 i_dat_vld,
  input  logic [DAT_WIDTH-1:0] i_dat,
  output logic                 o_dat_vld,
  output logic [DAT_WIDTH-1:0] o_dat,
  output logic                 o_busy
);

  logic [DEPTH-1:0]                vld_r;
  logic [DEPTH-1:0]                vld_nxt_s;
  logic [DEPTH-1:0][DAT_WIDTH-1:0] dat_r;
  logic [DEPTH-1:0][DAT_WIDTH-1:0] dat_nxt_s;

  // Shifted view of the stages: input enters stage 0, every stage moves up one.
  always_comb begin
    vld_nxt_s    = vld_r;
    dat_nxt_s    = dat_r;
    vld_nxt_s[0] = i_dat_vld;
    dat_nxt_s[0] = i_dat;
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt_s[i] = vld_r[i-1];
      dat_nxt_s[i] = dat_r[i-1];
    end
  end

  // Valid stages: flush wins over enable so a valid in the flush cycle is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
    end else if (i_flush) begin
      vld_r <= '0;
    end else if (i_en) begin
      vld_r <= vld_nxt_s;
    end else begin
      vld_r <= vld_r;
    end
  end

  // Data stages shift independently of valid; a flush leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_r <= '0;
    end else if (i_en && !i_flush) begin
      dat_r <= dat_nxt_s;
    end else begin
      dat_r <= dat_r;
    end
  end

  assign o_dat_vld = vld_r[DEPTH-1];
  assign o_dat     = dat_r[DEPTH-1];
  assign o_busy    = |vld_r;

endmodule

// File: rtl/skew_sr.sv
// -----------------------------------------------------------------------------
// skew_sr
// N_CH independent delay lines. Channel c is delayed by
// lane_depth(c, N_CH, BASE_DEPTH, STEP, REVERSE) enabled edges, giving either
// a staircase skew (REVERSE=0) or its inverse deskew (REVERSE=1).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_en          global shift enable, 0 stalls every lane
//   i_flush       synchronous clear of every valid stage
//   i_dat_vld     per-channel input valid             [N_CH]
//   i_dat         packed input data, channel c at [c*DAT_WIDTH +: DAT_WIDTH]
//   o_dat_vld     per-channel output valid            [N_CH]
//   o_dat         packed output data, same packing as i_dat
//   o_busy        high while any valid is in flight in any lane
// -----------------------------------------------------------------------------
module skew_sr
  import skew_sr_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DAT_WIDTH  = 16,
  parameter int BASE_DEPTH = 1,
  parameter int STEP       = 1,
  parameter int REVERSE    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic                      i_flush,
  input  logic [N_CH-1:0]           i_dat_vld,
  input  logic [N_CH*DAT_WIDTH-1:0] i_dat,
  output logic [N_CH-1:0]           o_dat_vld,
  output logic [N_CH*DAT_WIDTH-1:0] o_dat,
  output logic                      o_busy
);

  // Reject configurations that would produce empty or negative-depth lanes.
  if (N_CH < 32'sd1 || DAT_WIDTH < 32'sd1 || BASE_DEPTH < 32'sd1 || STEP < 32'sd0) begin : g_bad_param
    $error("skew_sr: illegal parameters N_CH=%0d DAT_WIDTH=%0d BASE_DEPTH=%0d STEP=%0d",
           N_CH, DAT_WIDTH, BASE_DEPTH, STEP);
  end

  logic [N_CH-1:0] lane_busy_s;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    localparam int LANE_DEPTH = lane_depth(c, N_CH, BASE_DEPTH, STEP, REVERSE);

    skew_sr_lane #(
      .DEPTH     (LANE_DEPTH),
      .DAT_WIDTH (DAT_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (i_en),
      .i_flush   (i_flush),
      .i_dat_vld (i_dat_vld[c]),
      .i_dat     (i_dat[c*DAT_WIDTH +: DAT_WIDTH]),
      .o_dat_vld (o_dat_vld[c]),
      .o_dat     (o_dat[c*DAT_WIDTH +: DAT_WIDTH]),
      .o_busy    (lane_busy_s[c])
    );
  end

  // Busy is built purely from flops, so it carries no path from the inputs.
  assign o_busy = |lane_busy_s;

endmodule

// File: doc/skew_sr.md
SKEW_SR -- requirements
Module: skew_sr

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent channels (lanes), N_CH >= 1.
REQ-002 SHALL have parameter DAT_WIDTH, default 16: data bits per channel.
REQ-003 SHALL have parameter BASE_DEPTH, default 1: delay of the least-delayed channel in enabled cycles, BASE_DEPTH >= 1.
REQ-004 SHALL have parameter STEP, default 1: extra delay per channel index, STEP >= 0.
REQ-005 SHALL have parameter REVERSE, default 0: 0 = skew (channel c delay BASE_DEPTH + c*STEP); 1 = deskew (channel c delay BASE_DEPTH + (N_CH-1-c)*STEP).
REQ-006 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_en  input  1  global shift enable; 0 = stall, all state held.
REQ-009 SHALL have port i_flush  input  1  synchronous clear of all valid bits.
REQ-010 SHALL have port i_dat_vld  input  N_CH  per-channel input valid.
REQ-011 SHALL have port i_dat  input  N_CH*DAT_WIDTH  packed input data, channel c at bits [c*DAT_WIDTH +: DAT_WIDTH].
REQ-012 SHALL have port o_dat_vld  output  N_CH  per-channel output valid.
REQ-013 SHALL have port o_dat  output  N_CH*DAT_WIDTH  packed output data, same packing as i_dat.
REQ-014 SHALL have port o_busy  output  1  high while any valid bit is in flight in any lane.

Function
REQ-015 SHALL implement, per channel c, a delay line of D(c) stages, with D(c) set by REVERSE as in REQ-005.
REQ-016 SHALL capture i_dat/i_dat_vld of channel c on an edge with i_en=1 and present them on o_dat/o_dat_vld of channel c after exactly D(c) further enabled edges, counting the capture edge as the first.
REQ-017 SHALL hold all stages unchanged on edges with i_en=0, so stall cycles do not count toward latency.
REQ-018 SHALL drive outputs directly from the last stage of each lane, with no combinational path from inputs to outputs.
REQ-019 SHALL shift data stages regardless of valid, so invalid slots carry don't-care data.
REQ-020 SHALL, on an edge with i_flush=1, clear every valid stage to 0 regardless of i_en, leaving data stages unchanged.
REQ-021 SHALL give i_flush priority over i_en and i_dat_vld: a valid presented in the flush cycle is discarded.
REQ-022 SHALL drive o_busy as the OR of all valid stages across all lanes, including last stages; o_busy low means the block is empty.
REQ-023 SHALL treat channels independently: a valid on one channel never affects another channel's valid or data.
REQ-024 SHALL, when STEP=0, give all channels delay BASE_DEPTH, so the block acts as an aligned N_CH-wide shift register.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear all valid stages and all data stages to 0.
REQ-026 SHALL hold o_dat_vld=0, o_dat=0 and o_busy=0 for as long as rst_n is low.
REQ-027 SHALL discard all in-flight data when reset is asserted mid-operation; the first valid output after release comes from a post-reset capture.

Structure
REQ-028 SHALL place a function lane_depth(c, N_CH, BASE_DEPTH, STEP, REVERSE) in package skew_sr_pkg, used by the RTL and by the bench.
REQ-029 SHALL instantiate one sub-module skew_sr_lane per channel: a single-channel delay line with depth parameter, i_en, i_flush, async reset, and valid plus data stages.
REQ-030 SHALL cause elaboration to fail when BASE_DEPTH < 1, N_CH < 1 or DAT_WIDTH < 1.

Verification
REQ-031 SHALL cover skew: with N_CH=4, DAT_WIDTH=8, BASE_DEPTH=1, STEP=1, REVERSE=0, drive all channels valid with data 0x10+c for one cycle -> channel c valid with 0x10+c exactly 1+c cycles after capture.
REQ-032 SHALL cover deskew: same stimulus with REVERSE=1 -> channel 3 out after 1 cycle, channel 0 after 4, and all outputs aligned when the input was pre-skewed by the skew configuration.
REQ-033 SHALL cover stall: i_en=0 for 3 cycles mid-flight -> every lane's latency grows by exactly 3 and data is intact.
REQ-034 SHALL cover flush: 4 valids in flight, i_flush=1 for one cycle with an input valid on channel 0 -> no further o_dat_vld, and o_busy=0 on the next cycle.
REQ-035 SHALL cover streaming: back-to-back valids with an incrementing pattern for 20 cycles on all channels -> per-channel output sequences identical to input, offset by D(c), with o_busy falling exactly D(3) cycles after the last input.
REQ-036 SHALL cover reset mid-operation: rst_n low for one cycle while lanes are full -> outputs 0 immediately, and no stale valids after release.
